// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between 16 clients and the round-robin arbiter.
// The master side drives requests and done; the slave side is the arbiter.
interface rr_arbiter_16_if;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid
  );
endinterface

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter: a thermometer mask above the last-released
// client selects the next winner; the grant is registered and held until done.
module rr_arbiter_16 (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_16_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [3:0]  ptr, ptr_next;
  logic [15:0] grant_r, grant_next;
  logic [3:0]  idx_r, idx_next;
  logic        valid_r, valid_next;

  logic [15:0] mask;
  logic [15:0] hi;
  logic [3:0]  winner;

  // Bits strictly above the pointer get priority.
  function automatic logic [15:0] thermo_mask(input logic [3:0] p);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) begin
      m[i] = (i > int'(p));
    end
    return m;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    mask   = thermo_mask(ptr);
    hi     = bus.req & mask;
    winner = (|hi) ? lowest_set(hi) : lowest_set(bus.req);
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    grant_next = grant_r;
    idx_next   = idx_r;
    valid_next = valid_r;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_next = 16'd1 << winner;
          idx_next   = winner;
          valid_next = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Pointer advances only on release, so an abandoned grant leaves no trace.
        if (bus.done) begin
          ptr_next   = idx_r;
          grant_next = '0;
          idx_next   = '0;
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        idx_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 4'd15;
      grant_r <= '0;
      idx_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      grant_r <= grant_next;
      idx_r   <= idx_next;
      valid_r <= valid_next;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_idx   = idx_r;
  assign bus.grant_valid = valid_r;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: a cyclic-search reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_rr_arbiter_16;

  logic clk;
  logic rst;

  rr_arbiter_16_if bus ();

  rr_arbiter_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: busy flag, last-released pointer, held index.
  logic       m_busy;
  logic [3:0] m_ptr;
  logic [3:0] m_idx;

  function automatic logic [3:0] next_winner(input logic [15:0] r, input logic [3:0] p);
    logic [3:0] w;
    logic       found;
    w = '0;
    found = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      if (!found && r[(int'(p) + j) % 16]) begin
        w = 4'((int'(p) + j) % 16);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_ptr  <= 4'd15;
      m_idx  <= 4'd0;
    end else if (!m_busy) begin
      if (bus.req != 16'd0) begin
        m_idx  <= next_winner(bus.req, m_ptr);
        m_busy <= 1'b1;
      end
    end else if (bus.done) begin
      m_ptr  <= m_idx;
      m_idx  <= 4'd0;
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_grant", 32'(bus.grant), m_busy ? 32'(16'd1 << m_idx) : 32'd0);
    check("model_idx",   32'(bus.grant_idx), m_busy ? 32'(m_idx) : 32'd0);
    check("model_valid", 32'(bus.grant_valid), 32'(m_busy));
  end

  // Returns at a negedge with grant_valid high, or flags a timeout.
  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (bus.grant_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.grant_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: grant_valid never rose within 20 cycles", name);
    end
  endtask

  task automatic pulse_done();
    @(negedge clk); #1 bus.done = 1'b1;
    @(negedge clk); #1 bus.done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req  = 16'hFFFF;
    bus.done = 1'b0;

    // Reset held 3 cycles with all clients requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_grant", 32'(bus.grant), 32'h0);
      check("rst_idx",   32'(bus.grant_idx), 32'h0);
      check("rst_valid", 32'(bus.grant_valid), 32'h0);
    end
    #1 rst = 1'b0;

    // Rotation: first grant after reset is client 0, then 1..15, 0.
    for (int k = 0; k < 17; k++) begin
      wait_grant("rot_wait");
      check("rot_idx", 32'(bus.grant_idx), 32'(k % 16));
      #1;
      pulse_done();
    end
    bus.req = 16'h0000;
    repeat (2) @(negedge clk);

    // Single client 5 (ptr = 0).
    #1 bus.req = 16'h0020;
    @(negedge clk);
    check("single_grant", 32'(bus.grant), 32'h0020);
    check("single_idx",   32'(bus.grant_idx), 32'd5);
    check("single_valid", 32'(bus.grant_valid), 32'd1);
    #1 bus.done = 1'b1;
    @(negedge clk);
    check("single_release", 32'(bus.grant_valid), 32'd0);
    check("single_rel_grant", 32'(bus.grant), 32'h0);
    #1 bus.done = 1'b0;
    bus.req = 16'h0000;
    @(negedge clk);

    // Wrap-around: ptr = 5 picks 9 over 3; then ptr = 9 wraps to 3.
    #1 bus.req = 16'h0208;
    wait_grant("wrap1_wait");
    check("wrap_idx9", 32'(bus.grant_idx), 32'd9);
    #1 bus.req = 16'h0008;
    pulse_done();
    wait_grant("wrap2_wait");
    check("wrap_idx3", 32'(bus.grant_idx), 32'd3);
    #1 bus.req = 16'h0000;
    pulse_done();

    // done in IDLE is ignored.
    @(negedge clk); #1 bus.done = 1'b1;
    @(negedge clk);
    check("idle_done_valid", 32'(bus.grant_valid), 32'd0);
    check("idle_done_grant", 32'(bus.grant), 32'h0);
    #1 bus.done = 1'b0;

    // Hold: client 2 keeps the grant after dropping its request.
    #1 bus.req = 16'h0004;
    wait_grant("hold_wait");
    #1 bus.req = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      check("hold_grant", 32'(bus.grant), 32'h0004);
    end
    pulse_done();
    check("hold_released", 32'(bus.grant_valid), 32'd0);

    // Reset mid-grant on client 7; afterwards ptr must be 15 again.
    #1 bus.req = 16'h0080;
    wait_grant("midrst_wait");
    check("midrst_idx7", 32'(bus.grant_idx), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("midrst_async_grant", 32'(bus.grant), 32'h0);
    check("midrst_async_valid", 32'(bus.grant_valid), 32'd0);
    bus.req = 16'h8001;
    @(negedge clk); #1 rst = 1'b0;
    wait_grant("postrst_wait");
    check("postrst_idx0", 32'(bus.grant_idx), 32'd0);
    #1 bus.req = 16'h0000;
    pulse_done();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
